// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the sync_fifo_param buffer: ordering-mode constants and
// the per-cycle operation decode used by the pointer/count control.
package sync_fifo_param_pkg;

    localparam int FIFO_MODE_QUEUE = 0;
    localparam int FIFO_MODE_STACK = 1;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_BOTH = 2'd3
    } fifo_op_e;

    // Accepted push/pop pair collapsed into a single operation code.
    function automatic fifo_op_e decode_op(input logic push_ok, input logic pop_ok);
        fifo_op_e op;
        case ({push_ok, pop_ok})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sync_fifo_storage.sv
// Storage array for sync_fifo_param: one synchronous write port and one
// asynchronous read port; contents are never reset.
module sync_fifo_storage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  Clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port: one entry per accepted push.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised queue/stack buffer with FWFT read, occupancy count and threshold flags.
// Optional sticky overflow/underflow flags are enabled by defining SYNC_FIFO_ERRFLAGS_EN.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int MODE       = 0,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iPush,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    input  logic                  iPop,
`ifdef SYNC_FIFO_ERRFLAGS_EN
    input  logic                  iClearErr,
    output logic                  oOverflow,
    output logic                  oUnderflow,
`endif
    output logic [DATA_WIDTH-1:0] oDataOut,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oAlmostFull,
    output logic                  oAlmostEmpty,
    output logic [ADDR_WIDTH:0]   oCount
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wptr_r, rptr_r, sp_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH-1:0] wptr_nxt_s, rptr_nxt_s, sp_nxt_s;
    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  full_s, empty_s, push_ok_s, pop_ok_s;
    fifo_op_e              op_s;

    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == {(ADDR_WIDTH + 1){1'b0}});
    assign pop_ok_s  = iPop & ~empty_s;
    // A pop in the same cycle frees the slot, so a full buffer still takes the push.
    assign push_ok_s = iPush & (~full_s | pop_ok_s);
    assign op_s      = decode_op(push_ok_s, pop_ok_s);

    // Next-state for pointers and count, plus storage addressing for the chosen ordering.
    always_comb begin
        wptr_nxt_s  = wptr_r;
        rptr_nxt_s  = rptr_r;
        sp_nxt_s    = sp_r;
        count_nxt_s = count_r;
        wr_addr_s   = wptr_r;
        rd_addr_s   = rptr_r;
        if (MODE == FIFO_MODE_STACK) begin
            rd_addr_s = sp_r - PTR_ONE;
            case (op_s)
                OP_PUSH: begin
                    wr_addr_s = sp_r;
                    sp_nxt_s  = sp_r + PTR_ONE;
                end
                OP_POP: begin
                    wr_addr_s = sp_r;
                    sp_nxt_s  = sp_r - PTR_ONE;
                end
                OP_BOTH: begin
                    // Replace the top entry in place.
                    wr_addr_s = sp_r - PTR_ONE;
                end
                default: begin
                    wr_addr_s = sp_r;
                end
            endcase
        end else begin
            if (push_ok_s) begin
                wptr_nxt_s = wptr_r + PTR_ONE;
            end else begin
                wptr_nxt_s = wptr_r;
            end
            if (pop_ok_s) begin
                rptr_nxt_s = rptr_r + PTR_ONE;
            end else begin
                rptr_nxt_s = rptr_r;
            end
        end
        case (op_s)
            OP_PUSH: count_nxt_s = count_r + CNT_ONE;
            OP_POP:  count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state register; reset discards contents by clearing pointers and count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wptr_r  <= {ADDR_WIDTH{1'b0}};
            rptr_r  <= {ADDR_WIDTH{1'b0}};
            sp_r    <= {ADDR_WIDTH{1'b0}};
            count_r <= {(ADDR_WIDTH + 1){1'b0}};
        end else begin
            wptr_r  <= wptr_nxt_s;
            rptr_r  <= rptr_nxt_s;
            sp_r    <= sp_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    sync_fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_storage (
        .Clock   (Clock),
        .wr_en   (push_ok_s),
        .wr_addr (wr_addr_s),
        .wr_data (iDataIn),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    assign oDataOut     = empty_s ? {DATA_WIDTH{1'b0}} : rd_data_s;
    assign oFull        = full_s;
    assign oEmpty       = empty_s;
    assign oAlmostFull  = (count_r >= AF_C);
    assign oAlmostEmpty = (count_r <= AE_C);
    assign oCount       = count_r;

`ifdef SYNC_FIFO_ERRFLAGS_EN
    logic overflow_r, underflow_r;

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (iPush & ~push_ok_s) begin
                overflow_r <= 1'b1;
            end else if (iClearErr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (iPop & empty_s) begin
                underflow_r <= 1'b1;
            end else if (iClearErr) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign oOverflow  = overflow_r;
    assign oUnderflow = underflow_r;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a queue and a stack instance share one stimulus stream and
// are compared every cycle against queue-based reference models.
module tb_sync_fifo_param;
    import sync_fifo_param_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          push  = 1'b0;
    logic          pop   = 1'b0;
    logic          clr   = 1'b0;
    logic [DW-1:0] din   = 32'd0;

    logic [DW-1:0] q_dout, s_dout;
    logic          q_full, q_empty, q_af, q_ae, s_full, s_empty, s_af, s_ae;
    logic [AW:0]   q_cnt, s_cnt;
    logic          q_ovf, q_unf, s_ovf, s_unf;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] q_model[$];
    logic [DW-1:0] s_model[$];
    logic          ovf_m = 1'b0;
    logic          unf_m = 1'b0;

    always #5 Clock = ~Clock;

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MODE(FIFO_MODE_QUEUE)) u_queue (
        .Clock(Clock), .Reset(Reset), .iPush(push), .iDataIn(din), .iPop(pop),
`ifdef SYNC_FIFO_ERRFLAGS_EN
        .iClearErr(clr), .oOverflow(q_ovf), .oUnderflow(q_unf),
`endif
        .oDataOut(q_dout), .oFull(q_full), .oEmpty(q_empty),
        .oAlmostFull(q_af), .oAlmostEmpty(q_ae), .oCount(q_cnt)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MODE(FIFO_MODE_STACK)) u_stack (
        .Clock(Clock), .Reset(Reset), .iPush(push), .iDataIn(din), .iPop(pop),
`ifdef SYNC_FIFO_ERRFLAGS_EN
        .iClearErr(clr), .oOverflow(s_ovf), .oUnderflow(s_unf),
`endif
        .oDataOut(s_dout), .oFull(s_full), .oEmpty(s_empty),
        .oAlmostFull(s_af), .oAlmostEmpty(s_ae), .oCount(s_cnt)
    );

`ifndef SYNC_FIFO_ERRFLAGS_EN
    assign q_ovf = 1'b0;
    assign q_unf = 1'b0;
    assign s_ovf = 1'b0;
    assign s_unf = 1'b0;
`endif

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: pop (if allowed) happens before push, so full+both keeps count.
    task automatic model_step(input logic p, input logic o, input logic [DW-1:0] d,
                              input logic r, input logic c);
        bit pop_ok, push_ok;
        if (r) begin
            q_model.delete();
            s_model.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            pop_ok  = o && (q_model.size() > 0);
            push_ok = p && ((q_model.size() < DEPTH) || pop_ok);
            if (p && !push_ok) ovf_m = 1'b1;
            else if (c) ovf_m = 1'b0;
            if (o && (q_model.size() == 0)) unf_m = 1'b1;
            else if (c) unf_m = 1'b0;
            if (pop_ok) begin
                void'(q_model.pop_front());
                void'(s_model.pop_back());
            end
            if (push_ok) begin
                q_model.push_back(d);
                s_model.push_back(d);
            end
        end
    endtask

    task automatic check_one(input string nm, input logic [DW-1:0] dout, input logic [AW:0] cnt,
                             input logic full, input logic empty, input logic af, input logic ae,
                             input logic ovf, input logic unf, input logic [DW-1:0] exp_head);
        int n;
        n = q_model.size();
        check({nm, "_count"}, DW'(cnt), DW'(n));
        check({nm, "_empty"}, DW'(empty), DW'(n == 0));
        check({nm, "_full"},  DW'(full),  DW'(n == DEPTH));
        check({nm, "_afull"}, DW'(af),    DW'(n >= DEPTH - 2));
        check({nm, "_aempty"}, DW'(ae),   DW'(n <= 1));
        check({nm, "_dout"},  dout, (n == 0) ? 32'd0 : exp_head);
`ifdef SYNC_FIFO_ERRFLAGS_EN
        check({nm, "_ovf"}, DW'(ovf), DW'(ovf_m));
        check({nm, "_unf"}, DW'(unf), DW'(unf_m));
`endif
    endtask

    task automatic cyc(input logic p, input logic o, input logic [DW-1:0] d,
                       input logic r = 1'b0, input logic c = 1'b0);
        push = p; pop = o; din = d; Reset = r; clr = c;
        @(posedge Clock);
        model_step(p, o, d, r, c);
        #1;
        check_one("q", q_dout, q_cnt, q_full, q_empty, q_af, q_ae, q_ovf, q_unf,
                  (q_model.size() > 0) ? q_model[0] : 32'd0);
        check_one("s", s_dout, s_cnt, s_full, s_empty, s_af, s_ae, s_ovf, s_unf,
                  (s_model.size() > 0) ? s_model[s_model.size() - 1] : 32'd0);
    endtask

    initial begin
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0);

        // Fill to full, then drain in order.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'h10 + i);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 32'd0);

        // Queue pointer wrap.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'h100 + i);
        for (int i = 0; i < 8; i++)  cyc(1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 32'h200 + i);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 32'd0);

        // Simultaneous push+pop on empty and on full.
        cyc(1'b1, 1'b1, 32'hAA);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 32'h300 + i);
        cyc(1'b1, 1'b1, 32'hBEEF);
        cyc(1'b1, 1'b1, 32'hCAFE);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 32'd0);

        // Stack-style sequence: replace top, then unwind.
        cyc(1'b1, 1'b0, 32'd1);
        cyc(1'b1, 1'b0, 32'd2);
        cyc(1'b1, 1'b0, 32'd3);
        cyc(1'b1, 1'b1, 32'd9);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'd0);

        // Reset mid-operation with a push pending.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h400 + i);
        cyc(1'b1, 1'b0, 32'h4FF, 1'b1);
        cyc(1'b0, 1'b0, 32'd0);

        // Rejected requests and sticky error flags.
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 32'h500 + i);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 32'h5FF, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Randomised traffic with occasional reset and clear.
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), $urandom(),
                1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 99) < 5));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
